// File: rtl/h_axi_write_front.sv
// h_axi_write_front: AXI4 write-channel front end of the AXI->AHB bridge (AW latch, W beat pass, B return).
// Latency: AW accept -> w_ready possible from the next cycle; last beat -> b_valid the next cycle.
// Backpressure: w_ready follows beat_ready only in DATA; B held stable until b_ready; one burst outstanding.
// Optional feature: define H_AXI_WR_TIMEOUT_EN to close a burst with SLVERR after TIMEOUT idle W cycles.
module h_axi_write_front #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                resetn,
  // AW channel
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [ID_W-1:0]     aw_id,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic [3:0]          aw_len,
  input  logic [2:0]          aw_size,
  // W channel
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  input  logic                w_last,
  // B channel
  output logic                b_valid,
  input  logic                b_ready,
  output logic [ID_W-1:0]     b_id,
  output logic [1:0]          b_resp,
  // burst parameters to the AHB address counter
  output logic [ADDR_W-1:0]   base_addr,
  output logic [3:0]          len,
  output logic [2:0]          size,
  // beat interface to the AHB write stage
  input  logic                beat_ready,
  output logic                beat_fire,
  output logic                beat_last,
  output logic [DATA_W-1:0]   beat_data,
  output logic [DATA_W/8-1:0] beat_strb,
  input  logic                len_error,
  input  logic                hresp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        len_q;
  logic [2:0]        size_q;
  logic              err_q;
  logic [3:0]        beat_cnt_q;

  logic size_illegal;
  logic aw_fire;
  logic b_fire;
  logic timeout_hit;

  // A beat wider than the data bus cannot be carried, so the burst is flagged at AW time.
  assign size_illegal = (32'd8 << aw_size) > 32'(DATA_W);

  assign aw_fire   = aw_valid & aw_ready;
  assign b_fire    = b_valid & b_ready;
  assign beat_fire = w_valid & w_ready;
  assign beat_last = beat_fire & w_last;
  assign beat_data = w_data;
  assign beat_strb = w_strb;

  assign b_id      = id_q;
  assign base_addr = addr_q;
  assign len       = len_q;
  assign size      = size_q;
  // Response code only presented while B is valid; an error anywhere in the burst yields one SLVERR.
  assign b_resp    = (b_valid && err_q) ? 2'b10 : 2'b00;

`ifdef H_AXI_WR_TIMEOUT_EN
  logic [7:0] idle_cnt_q;

  assign timeout_hit = (state == DATA) && !beat_fire && (idle_cnt_q == 8'(TIMEOUT - 1));

  // Count consecutive DATA cycles without a transferred beat; any beat restarts the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle_cnt_q <= 8'd0;
    end else if (state != DATA || beat_fire || timeout_hit) begin
      idle_cnt_q <= 8'd0;
    end else begin
      idle_cnt_q <= idle_cnt_q + 8'd1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = ^(32'(TIMEOUT));
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; W is only accepted while a burst is open.
  always_comb begin
    state_nxt = state;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    case (state)
      IDLE: begin
        aw_ready = 1'b1;
        if (aw_valid) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        w_ready = beat_ready;
        if (w_valid && beat_ready && w_last) begin
          state_nxt = RESP;
        end else if (timeout_hit) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        b_valid = 1'b1;
        if (b_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Burst context, error accumulation and beat counting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= 4'd0;
      size_q     <= 3'd0;
      err_q      <= 1'b0;
      beat_cnt_q <= 4'd0;
    end else begin
      if (aw_fire) begin
        id_q       <= aw_id;
        addr_q     <= aw_addr;
        len_q      <= aw_len;
        size_q     <= aw_size;
        err_q      <= size_illegal;
        beat_cnt_q <= 4'd0;
      end else if (state == DATA) begin
        if (beat_fire) begin
          beat_cnt_q <= beat_cnt_q + 4'd1;
          // beat_cnt_q counts beats before this one, so on the last beat it must equal len.
          err_q <= err_q | hresp_err | (w_last & (len_error | (beat_cnt_q != len_q)));
        end else if (timeout_hit) begin
          err_q <= 1'b1;
        end
      end else if (b_fire) begin
        err_q      <= 1'b0;
        beat_cnt_q <= 4'd0;
      end
    end
  end

endmodule
